cache_way_ctrl: RTL and testbench

//  Way-selection and miss-sequencing controller for the 4-way set-associative write-back/allocate cache.

---
 rtl/cache_way_ctrl_pkg.sv | 32 +++
 rtl/cache_way_ctrl_plru4_tree.sv | 28 ++
 rtl/cache_way_ctrl.sv | 165 ++++++++++++++++
 tb/tb_cache_way_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_way_ctrl_pkg.sv
// Shared definitions for the 4-way cache way-selection / miss-sequencing controller.
// Holds the controller state encoding, the PLRU geometry and small vector helpers.
package cache_way_ctrl_pkg;

    localparam int WAYS   = 4;
    localparam int PLRU_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_WB     = 3'd2,
        ST_FILL   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Index of the lowest set bit; an all-zero vector maps to way 0.
    function automatic logic [1:0] lowest_way(input logic [WAYS-1:0] v);
        logic [1:0] w;
        w = 2'd0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                w = i[1:0];
            end
        end
        return w;
    endfunction

    function automatic logic multi_hot(input logic [WAYS-1:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

endpackage

// File: rtl/cache_way_ctrl_plru4_tree.sv
// Tree pseudo-LRU for one 4-way set: victim choice and the state after touching a way.
// b0 chooses the pair, b1 / b2 choose within ways {0,1} / {2,3}.
module plru4_tree
    import cache_way_ctrl_pkg::*;
(
    input  logic [PLRU_W-1:0] cur_bits,
    input  logic [1:0]        access_way,
    output logic [1:0]        victim,
    output logic [PLRU_W-1:0] next_bits
);

    // Victim walk and MRU update: every node on the touched path points away from it.
    always_comb begin
        next_bits = cur_bits;
        if (cur_bits[0]) begin
            victim = {1'b1, cur_bits[2]};
        end else begin
            victim = {1'b0, cur_bits[1]};
        end
        next_bits[0] = ~access_way[1];
        if (access_way[1]) begin
            next_bits[2] = ~access_way[0];
        end else begin
            next_bits[1] = ~access_way[0];
        end
    end

endmodule

// File: rtl/cache_way_ctrl.sv
// Way-select and miss sequencer for the 4-way write-back/allocate cache: picks the hit way or
// a victim, runs write-back then fill handshakes, and keeps per-set tree PLRU state in flops.
module cache_way_ctrl
    import cache_way_ctrl_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_index,
    input  logic [3:0]       req_hit,
    input  logic [3:0]       req_valid_v,
    input  logic [3:0]       req_dirty_v,
    output logic [1:0]       way_sel,
    output logic             hit,
    output logic             wb_req,
    input  logic             wb_done,
    output logic             fill_req,
    input  logic             fill_done,
    output logic             done,
    output logic             multi_hit_err
);

    state_t              state_r;
    logic [IDX_W-1:0]    idx_r;
    logic [3:0]          hit_v_r;
    logic [3:0]          valid_v_r;
    logic [3:0]          dirty_v_r;
    logic [PLRU_W-1:0]   plru_r [SETS];

    logic [PLRU_W-1:0]   plru_cur_s;
    logic [PLRU_W-1:0]   plru_next_s;
    logic [1:0]          victim_s;
    logic [1:0]          hit_way_s;
    logic [1:0]          miss_way_s;
    logic [1:0]          access_way_s;
    logic                plru_upd_s;

    assign plru_cur_s = plru_r[idx_r];

    plru4_tree u_plru (
        .cur_bits   (plru_cur_s),
        .access_way (access_way_s),
        .victim     (victim_s),
        .next_bits  (plru_next_s)
    );

    // Way choice: lowest hit, else lowest invalid way, else the PLRU victim.
    always_comb begin
        hit_way_s = lowest_way(hit_v_r);
        if (valid_v_r != 4'b1111) begin
            miss_way_s = lowest_way(~valid_v_r);
        end else begin
            miss_way_s = victim_s;
        end
        if (state_r == ST_LOOKUP) begin
            access_way_s = hit_way_s;
        end else begin
            access_way_s = way_sel;
        end
        if (state_r == ST_LOOKUP) begin
            plru_upd_s = (hit_v_r != 4'b0000);
        end else if (state_r == ST_FILL) begin
            plru_upd_s = fill_done;
        end else begin
            plru_upd_s = 1'b0;
        end
    end

    // PLRU flop array, cleared in a single reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                plru_r[s] <= {PLRU_W{1'b0}};
            end
        end else if (plru_upd_s) begin
            plru_r[idx_r] <= plru_next_s;
        end
    end

    // Controller FSM; done and req_ready are registered, so req_ready stays low through the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            idx_r         <= {IDX_W{1'b0}};
            hit_v_r       <= 4'b0000;
            valid_v_r     <= 4'b0000;
            dirty_v_r     <= 4'b0000;
            req_ready     <= 1'b1;
            way_sel       <= 2'd0;
            hit           <= 1'b0;
            wb_req        <= 1'b0;
            fill_req      <= 1'b0;
            done          <= 1'b0;
            multi_hit_err <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done          <= 1'b0;
                    multi_hit_err <= 1'b0;
                    if (req_valid && req_ready) begin
                        idx_r     <= req_index;
                        hit_v_r   <= req_hit;
                        valid_v_r <= req_valid_v;
                        dirty_v_r <= req_dirty_v;
                        req_ready <= 1'b0;
                        state_r   <= ST_LOOKUP;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_LOOKUP: begin
                    if (hit_v_r != 4'b0000) begin
                        way_sel <= hit_way_s;
                        hit     <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        way_sel <= miss_way_s;
                        hit     <= 1'b0;
                        if (valid_v_r[miss_way_s] && dirty_v_r[miss_way_s]) begin
                            wb_req  <= 1'b1;
                            state_r <= ST_WB;
                        end else begin
                            fill_req <= 1'b1;
                            state_r  <= ST_FILL;
                        end
                    end
                end
                ST_WB: begin
                    if (wb_done) begin
                        wb_req   <= 1'b0;
                        fill_req <= 1'b1;
                        state_r  <= ST_FILL;
                    end else begin
                        wb_req <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (fill_done) begin
                        fill_req <= 1'b0;
                        state_r  <= ST_DONE;
                    end else begin
                        fill_req <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done          <= 1'b1;
                    multi_hit_err <= multi_hot(hit_v_r);
                    state_r       <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    req_ready <= 1'b1;
                    wb_req    <= 1'b0;
                    fill_req  <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_way_ctrl.sv
// Randomised self-checking bench for cache_way_ctrl against a per-set tree-PLRU reference model.
module tb_cache_way_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_index;
    logic [3:0] req_hit;
    logic [3:0] req_valid_v;
    logic [3:0] req_dirty_v;
    logic [1:0] way_sel;
    logic       hit;
    logic       wb_req;
    logic       wb_done;
    logic       fill_req;
    logic       fill_done;
    logic       done;
    logic       multi_hit_err;

    int checks   = 0;
    int failures = 0;
    int model_plru [64];

    cache_way_ctrl #(.SETS(64), .IDX_W(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_index     (req_index),
        .req_hit       (req_hit),
        .req_valid_v   (req_valid_v),
        .req_dirty_v   (req_dirty_v),
        .way_sel       (way_sel),
        .hit           (hit),
        .wb_req        (wb_req),
        .wb_done       (wb_done),
        .fill_req      (fill_req),
        .fill_done     (fill_done),
        .done          (done),
        .multi_hit_err (multi_hit_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Tree walk: the root bit names the pair to evict from, the pair bit the way inside it.
    function automatic int model_victim(input int idx);
        int b;
        b = model_plru[idx];
        return b[0] ? 2 + b[2] : b[1];
    endfunction

    // Touching a way turns every tree node on its path to point at the other side.
    task automatic model_touch(input int idx, input int w);
        int b;
        b = model_plru[idx];
        if (w < 2) begin
            b[0] = 1;
            b[1] = (w == 0);
        end else begin
            b[0] = 0;
            b[2] = (w == 2);
        end
        model_plru[idx] = b;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model_plru[i] = 0;
    endtask

    task automatic run_req(input int idx, input logic [3:0] hv, input logic [3:0] vv,
                           input logic [3:0] dv, input bit noisy, output int got_way);
        int ew;
        int cyc;
        bit ehit, ewb, emhe, saw_wb, saw_fill, seen_done, seen_req;
        ehit = (hv != 4'b0000);
        ewb  = 1'b0;
        if (ehit) begin
            ew = lowest(hv);
        end else begin
            ew  = (vv != 4'b1111) ? lowest(~vv) : model_victim(idx);
            ewb = vv[ew] && dv[ew];
        end
        emhe = ($countones(hv) > 1);

        @(negedge clk);
        req_valid   = 1'b1;
        req_index   = idx[5:0];
        req_hit     = hv;
        req_valid_v = vv;
        req_dirty_v = dv;
        wb_done     = 1'b0;
        fill_done   = 1'b0;
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("accept_ready", req_ready, 1);
        @(negedge clk);

        cyc = 0; seen_done = 0; saw_wb = 0; saw_fill = 0; seen_req = 0; got_way = -1;
        while (!seen_done && cyc < 300) begin
            if (done) begin
                seen_done = 1;
                got_way = way_sel;
                if (ehit) check_eq("hit_latency", cyc, 2);
                check_eq("way_sel", way_sel, ew);
                check_eq("hit", hit, ehit);
                check_eq("multi_hit_err", multi_hit_err, emhe);
                check_eq("saw_wb", saw_wb, ewb);
                check_eq("saw_fill", saw_fill, !ehit);
                check_eq("ready_low_at_done", req_ready, 0);
            end else begin
                if (wb_req) saw_wb = 1;
                if (fill_req) saw_fill = 1;
                if ((wb_req || fill_req) && !seen_req) begin
                    seen_req = 1;
                    check_eq("way_sel_at_mem_req", way_sel, ew);
                    check_eq("wb_first_if_dirty", wb_req, ewb);
                end
                if (wb_req && fill_req) check_eq("wb_fill_exclusive", 1, 0);
            end
            req_valid = noisy ? 1'($urandom % 2) : 1'b0;
            if (noisy) begin
                req_index   = 6'($urandom);
                req_hit     = 4'($urandom);
                req_valid_v = 4'($urandom);
                req_dirty_v = 4'($urandom);
            end
            wb_done   = wb_req   ? ($urandom % 3 == 0) : (noisy ? 1'($urandom % 2) : 1'b0);
            fill_done = fill_req ? ($urandom % 3 == 0) : (noisy ? 1'($urandom % 2) : 1'b0);
            if (!seen_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        check_eq("done_seen", seen_done, 1);
        @(negedge clk);
        req_valid = 1'b0;
        wb_done   = 1'b0;
        fill_done = 1'b0;
        check_eq("done_pulse_1cyc", done, 0);
        model_touch(idx, ew);
    endtask

    initial begin
        int w;
        int cyc;
        int exp4 [4] = '{0, 2, 1, 3};
        rst = 1'b1; req_valid = 1'b0; req_index = 6'd0; req_hit = 4'd0;
        req_valid_v = 4'd0; req_dirty_v = 4'd0; wb_done = 1'b0; fill_done = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_way_sel", way_sel, 0);
        check_eq("rst_hit", hit, 0);
        check_eq("rst_wb_req", wb_req, 0);
        check_eq("rst_fill_req", fill_req, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_mhe", multi_hit_err, 0);

        run_req(5, 4'b0100, 4'b0100, 4'b0000, 1'b0, w);
        check_eq("t1_way", w, 2);
        run_req(0, 4'b0000, 4'b0000, 4'b0000, 1'b0, w);
        check_eq("t2_cold_way", w, 0);
        run_req(3, 4'b0000, 4'b1111, 4'b0001, 1'b0, w);
        check_eq("t3_dirty_way", w, 0);
        for (int i = 0; i < 4; i++) begin
            run_req(7, 4'b0000, 4'b1111, 4'b0000, 1'b0, w);
            check_eq("t4_victim_seq", w, exp4[i]);
        end
        run_req(10, 4'b1010, 4'b1111, 4'b0000, 1'b0, w);
        check_eq("t5_multi_way", w, 1);

        // Abort a write-back with reset, then make sure nothing of the old state survives.
        @(negedge clk);
        req_valid = 1'b1; req_index = 6'd9; req_hit = 4'b0000;
        req_valid_v = 4'b1111; req_dirty_v = 4'b1111;
        cyc = 0;
        while (!wb_req && cyc < 50) begin
            @(negedge clk);
            req_valid = 1'b0;
            cyc++;
        end
        check_eq("t6_wb_req_up", wb_req, 1);
        rst = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t6_wb_dropped", wb_req, 0);
        check_eq("t6_fill_low", fill_req, 0);
        check_eq("t6_ready", req_ready, 1);
        model_clear();
        fill_done = 1'b1;
        @(negedge clk);
        fill_done = 1'b0;
        check_eq("t6_stray_fill_ready", req_ready, 1);
        check_eq("t6_stray_fill_done", done, 0);
        run_req(3, 4'b0000, 4'b1111, 4'b0000, 1'b0, w);
        check_eq("t6_plru_cleared", w, 0);

        for (int n = 0; n < 300; n++) begin
            logic [3:0] hv;
            hv = ($urandom % 3 == 0) ? 4'($urandom) : 4'b0000;
            run_req(int'($urandom % 8), hv, 4'($urandom | ($urandom % 2 ? 4'hf : 4'h0)),
                    4'($urandom), 1'b1, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
